// File: rtl/dram_pkg.sv
// Constants and state type shared by the DRAM sample packer and unpacker.
// Both sides agree on a 128-bit line holding four 32-bit samples.
package dram_pkg;

  localparam int LINE_BYTES       = 16;
  localparam int SAMPLES_PER_LINE = 4;
  localparam int ADX_W            = 27;
  localparam int LINE_W           = 128;
  localparam int SAMPLE_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } unpack_state_e;

endpackage

// File: rtl/dram_unpacker.sv
// Turns per-sample read requests into 128-bit DRAM line reads.
// The last returned line is cached so sequential readback needs one read per four samples.
module dram_unpacker
  import dram_pkg::*;
#(
  parameter int               IDX_W          = 25,
  parameter logic [ADX_W-1:0] BASE_ADX       = 27'h0,
  parameter int               TIMEOUT_CYCLES = 4096,
  parameter int               TO_W           = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_req,
  input  logic [IDX_W-1:0]    sample_index,
  input  logic                cache_invalidate,
  output logic                busy,
  output logic                sample_valid,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                read_req,
  output logic [ADX_W-1:0]    rd_adx,
  input  logic                read_allowed,
  input  logic                has_return_data,
  output logic                get_return_data,
  input  logic [LINE_W-1:0]   return_data,
  input  logic [ADX_W-1:0]    return_adx,
  output logic                adx_error,
  output logic                timeout
);

  localparam int LN_W = IDX_W - 2;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [SAMPLE_W-1:0] lane_sel(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        lane);
    return line[{lane, 5'b00000} +: SAMPLE_W];
  endfunction

  unpack_state_e    state_q, state_d;
  logic             cache_valid_q, cache_valid_d;
  logic             inv_pend_q, inv_pend_d;
  logic             adx_error_q, adx_error_d;
  logic             timeout_q, timeout_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [ADX_W-1:0] rd_adx_q, rd_adx_d;

  logic [LINE_W-1:0] line_q, line_d;
  logic [LN_W-1:0]   cached_line_q, cached_line_d;
  logic [LN_W-1:0]   req_line_q, req_line_d;
  logic [1:0]        lane_q, lane_d;

  logic [LN_W-1:0]   in_line;
  assign in_line = sample_index[IDX_W-1:2];

  always_comb begin
    state_d         = state_q;
    cache_valid_d   = cache_valid_q;
    inv_pend_d      = inv_pend_q;
    adx_error_d     = adx_error_q;
    timeout_d       = timeout_q;
    cnt_d           = cnt_q;
    rd_adx_d        = rd_adx_q;
    line_d          = line_q;
    cached_line_d   = cached_line_q;
    req_line_d      = req_line_q;
    lane_d          = lane_q;
    read_req        = 1'b0;
    get_return_data = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sample_req) begin
          lane_d = sample_index[1:0];
          if (cache_valid_q && !cache_invalidate && (in_line == cached_line_q)) begin
            state_d = ST_RESP;
          end else begin
            req_line_d = in_line;
            rd_adx_d   = BASE_ADX + ADX_W'({in_line, 4'b0000});
            inv_pend_d = 1'b0;
            state_d    = ST_ISSUE;
          end
        end else if (has_return_data) begin
          // Leftover return from before a reset or an abort: discard it.
          get_return_data = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (read_allowed) begin
          read_req = 1'b1;
          cnt_d    = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (has_return_data) begin
          get_return_data = 1'b1;
          line_d          = return_data;
          if (return_adx == rd_adx_q) begin
            cached_line_d = req_line_q;
            cache_valid_d = !inv_pend_q;
          end else begin
            adx_error_d   = 1'b1;
            cache_valid_d = 1'b0;
          end
          state_d = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          // Zeroed line makes the aborted response read back as 0.
          timeout_d     = 1'b1;
          cache_valid_d = 1'b0;
          line_d        = '0;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A line fetched while an invalidate was seen must not be reused.
    if (cache_invalidate) begin
      cache_valid_d = 1'b0;
      if (state_q != ST_IDLE) inv_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cache_valid_q <= 1'b0;
      inv_pend_q    <= 1'b0;
      adx_error_q   <= 1'b0;
      timeout_q     <= 1'b0;
      cnt_q         <= '0;
      rd_adx_q      <= '0;
    end else begin
      state_q       <= state_d;
      cache_valid_q <= cache_valid_d;
      inv_pend_q    <= inv_pend_d;
      adx_error_q   <= adx_error_d;
      timeout_q     <= timeout_d;
      cnt_q         <= cnt_d;
      rd_adx_q      <= rd_adx_d;
    end
  end

  always_ff @(posedge clk) begin
    line_q        <= line_d;
    cached_line_q <= cached_line_d;
    req_line_q    <= req_line_d;
    lane_q        <= lane_d;
  end

  assign busy         = (state_q != ST_IDLE);
  assign sample_valid = (state_q == ST_RESP);
  assign sample_data  = sample_valid ? lane_sel(line_q, lane_q) : '0;
  assign rd_adx       = rd_adx_q;
  assign adx_error    = adx_error_q;
  assign timeout      = timeout_q;

endmodule

// File: doc/dram_unpacker.md
Name: dram_unpacker

Overview:
- Read-side counterpart to the write-side sample packer. Sits between the DDR2 memory interface's read-return path and the logic-capture readback logic.
- Converts a per-sample read request (32-bit sample index) into 128-bit line reads. Each line holds 4 packed 32-bit samples.
- Caches the last returned line so sequential readback costs one DRAM read per 4 samples, and returns one 32-bit sample with a valid strobe.

Parameters:
- IDX_W, 25, width of sample_index (4 samples/line × 2^23 lines = 128 MB).
- BASE_ADX, 27'h0, byte address of sample 0 in DRAM.
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for return data before aborting.
- TO_W, 13, width of the timeout counter.

Ports:
- clk  in  1  SoC clock (100 MHz, memory-interface domain).
- reset  in  1  asynchronous, active-high reset.
- sample_req  in  1  single-cycle request for one sample.
- sample_index  in  IDX_W  index of the requested sample; sampled when sample_req && !busy.
- cache_invalidate  in  1  single-cycle pulse; drop the cached line (new capture started).
- busy  out  1  high while a request is in progress; new requests are ignored.
- sample_valid  out  1  single-cycle strobe; sample_data is valid.
- sample_data  out  32  requested sample.
- read_req  out  1  single-cycle read command to the memory interface.
- rd_adx  out  27  byte address for read_req; 16-byte aligned.
- read_allowed  in  1  memory interface accepts read_req this cycle.
- has_return_data  in  1  return FIFO non-empty (first-word fall-through).
- get_return_data  out  1  pop the return FIFO.
- return_data  in  128  returned line.
- return_adx  in  27  address tag of the returned line.
- adx_error  out  1  sticky; return_adx did not match the issued rd_adx.
- timeout  out  1  sticky; the WAIT state exceeded TIMEOUT_CYCLES.

Behaviour:
- Reset values: all outputs 0; cache_valid=0; state=IDLE.
- Address mapping:
  - line = sample_index[IDX_W-1:2].
  - rd_adx = BASE_ADX + {line,4'b0000}, truncated to 27 bits (wrap allowed).
  - lane = sample_index[1:0]; sample_data = line_q[32*lane+31 : 32*lane].
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - sample_req with cache_valid and line==cached_line (hit): latch lane, go to RESP.
  - sample_req otherwise (miss): latch line and lane, compute rd_adx, go to ISSUE.
  - No request and has_return_data=1: stale return (e.g. left over from reset or an abort). Pulse get_return_data to discard it and stay in IDLE.
- ISSUE: when read_allowed=1, assert read_req for exactly one cycle and go to WAIT. rd_adx is held stable from ISSUE entry through WAIT.
- WAIT:
  - Timeout counter starts at 0 on entry.
  - When has_return_data=1: assert get_return_data for one cycle and capture return_data/return_adx in that same cycle.
  - If return_adx==rd_adx: cached_line=line, cache_valid=1. Otherwise set adx_error, cache_valid=0, and still deliver the captured data.
  - Go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without data: set timeout, cache_valid=0, go to RESP with sample_data forced to 32'h0.
- RESP: sample_valid=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Latency from sample_req to sample_valid:
  - Hit: 1 cycle.
  - Miss: 1 + ISSUE wait + 1 + return wait + 1.
- sample_req while busy: ignored; no queueing.
- cache_invalidate: clears cache_valid in any state, including mid-miss. The in-flight line is still delivered but is not cached.
- Simultaneous cache_invalidate and sample_req in IDLE: invalidate takes priority; the request is treated as a miss.
- Stale-drain rule applies only in IDLE. In WAIT the first return is accepted and checked by tag.
- adx_error and timeout clear only on reset.

Decomposition:
- Shared package dram_pkg: LINE_BYTES=16, SAMPLES_PER_LINE=4, ADX_W=27, LINE_W=128, state enum for the unpacker. The packer shares the same constants.
- No sub-module. The lane mux is an inline function.

Test Plan:
- Cold miss: reset, req index 5, read_allowed=1, return after 10 cycles with line {32'hD,32'hC,32'hB,32'hA}, tag 27'h10 → read_req once with rd_adx=27'h10; sample_data=32'hB; cache_valid=1.
- Hit: after the cold miss, req index 6 → sample_valid next cycle, sample_data=32'hC, no read_req.
- Invalidate: cache_invalidate then req index 6 → new read_req at 27'h10. Same test with invalidate pulsed during WAIT → line delivered, next req 7 still misses.
- Backpressure/tag: read_allowed held low for 20 cycles → read_req only after it rises. Return tag 27'h20 vs issued 27'h10 → adx_error=1, data still delivered.
- Timeout: TIMEOUT_CYCLES=16, no return → sample_valid with 32'h0 at cycle 16 of WAIT, timeout=1, busy drops.
- Reset/stale: assert reset during WAIT, then present has_return_data=1 in IDLE → one get_return_data pulse, no sample_valid, outputs 0.
